ide_pio_sequencer: RTL and testbench
====================================

// Module: ide_pio_sequencer
// PURPOSE
//  Cycle sequencer between the Zorro II bus decode and the ATA interface. Once autoconfig/address decode flags an
//  IDE access, it times the ATA PIO cycle (CS setup, IOR_n/IOW_n strobe, IORDY wait, recovery) and the Zorro DTACK.
//  It also produces the synchronised AS_n_S4 that gates the IDE data buffer OE and the boot ROM enable.
// PARAMETERS
//  SETUP_CYC      1   CLK7M cycles CS valid before strobe (t1)
//  ACTIVE_CYC     2   minimum CLK7M cycles strobe low (t2)
//  RECOVER_CYC    1   CLK7M cycles CS held after strobe release (t9)
//  IORDY_TIMEOUT  64  max CLK7M cycles spent waiting on IORDY
// PORTS
//  CLK7M       in   1  7.09 MHz bus clock
//  RESET_n     in   1  reset: synchronous, active-low
//  AS_n        in   1  68k address strobe, asynchronous
//  UDS_n       in   1  upper data strobe, asynchronous
//  LDS_n       in   1  lower data strobe, asynchronous
//  RW          in   1  1 = read, 0 = write
//  ADDR        in   5  ADDR[16:12]; [16]=1 register window, [16]=0 ROM window; [12] selects CS2 vs CS1
//  ide_access  in   1  address hits the configured IDE board
//  ide_enable  in   1  IDE function enabled (jumper, latched at reset)
//  IORDY       in   1  ATA IORDY (1 = ready)
//  IOR_n       out  1  ATA read strobe
//  IOW_n       out  1  ATA write strobe
//  IDECS1_n    out  1  ATA command-block select
//  IDECS2_n    out  1  ATA control-block select
//  IDE_ROMEN   out  1  boot ROM output enable
//  AS_n_S4     out  1  AS_n after 2-flop synchroniser
//  DTACK       out  1  active-high ack request to top level
//  timeout     out  1  one-cycle pulse: IORDY wait expired
// BEHAVIOUR
//  - Reset: IOR_n=IOW_n=IDECS1_n=IDECS2_n=1, IDE_ROMEN=0, DTACK=0, timeout=0, AS_n_S4=1, state IDLE, counters 0.
//    Reset mid-cycle aborts immediately with these values; no partial strobe survives.
//  - AS_n, UDS_n, LDS_n pass 2-flop synchronisers; as_s = AS_n_S4, ds_s = !(UDS_n_s & LDS_n_s).
//  - start = ide_access & ide_enable & !as_s & ds_s, sampled only in IDLE.
//  - States: IDLE, SETUP, ACTIVE, WAIT_RDY, ACK, RECOVER, ROMACK. One counter, 8 bits, loaded on entry.
//  - IDLE: start & ADDR[16] -> SETUP (cnt=SETUP_CYC-1); start & !ADDR[16] -> ROMACK.
//  - SETUP: CS (ADDR[12]? IDECS2_n : IDECS1_n) low; cnt==0 -> ACTIVE (cnt=ACTIVE_CYC-1).
//  - ACTIVE: CS low; IOR_n low if RW else IOW_n low; cnt==0 -> WAIT_RDY (with IORDY gate) or ACK.
//  - WAIT_RDY: strobe held; IORDY=1 -> ACK; cnt reaches IORDY_TIMEOUT-1 -> ACK with timeout pulse.
//  - ACK: DTACK=1, strobe and CS held so read data stays valid; as_s=1 -> RECOVER (cnt=RECOVER_CYC-1).
//  - RECOVER: strobes released (1), DTACK=0, CS held low; cnt==0 -> IDLE. Back-to-back start waits for IDLE.
//  - ROMACK: IDE_ROMEN=1 while RW=1, DTACK=1 from the next cycle; as_s=1 -> IDLE with IDE_ROMEN=0.
//  - Abort: as_s=1 in SETUP/ACTIVE/WAIT_RDY (BERR, bus relinquish) -> RECOVER, DTACK never asserted.
//  - Strobe edges are registered outputs, glitch-free; IOR_n and IOW_n are never low together.
//  - Latency start -> DTACK: 2 sync + SETUP_CYC + ACTIVE_CYC + 1 cycles (6 at defaults, IORDY high).
// CONFIGURATION
//  IDE_IORDY_EN defined: WAIT_RDY state present; IORDY sampled through 1 flop; timeout active.
//  IDE_IORDY_EN undefined: ACTIVE -> ACK directly; IORDY ignored; timeout tied 0; no WAIT_RDY logic.
// STRUCTURE
//  Package ide_pkg: state enum, default timing constants, counter width localparam.
//  Sub-module sync2 (2-flop synchroniser, reset to 1) instantiated for AS_n, UDS_n, LDS_n; FSM stays flat.
// TESTING
//  Register read ADDR=5'h10, RW=1, IORDY=1 -> CS1_n low 1 cyc, IOR_n low, DTACK 6 cyc after AS_n fall; release on AS_n rise.
//  Write ADDR=5'h11, RW=0 -> IDECS2_n low, IOW_n low >=2 cyc, IOR_n stays 1, CS held 1 cyc after IOW_n rise.
//  ROM read ADDR=5'h00 -> IDE_ROMEN=1, no CS/strobe activity, DTACK next cycle; IDE_ROMEN=0 after AS_n rise.
//  IDE_IORDY_EN, IORDY=0 held -> strobe held 64 cyc, timeout pulse, then DTACK; IORDY=1 at cyc 5 -> DTACK next cyc.
//  AS_n deasserted during ACTIVE -> strobe released next cyc, DTACK never 1, back to IDLE after RECOVER.
//  RESET_n low during ACTIVE, or ide_enable=0 with access -> all outputs inactive, no cycle started.

Source files
------------

// File: rtl/ide_pkg.sv
// Shared types and default timing for the IDE PIO sequencer.
// Timing constants are in CLK7M cycles; the counter is wide enough for the IORDY wait limit.
package ide_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        WAIT_RDY,
        ACK,
        RECOVER,
        ROMACK
    } state_t;

    localparam int CNT_W             = 8;
    localparam int DEF_SETUP_CYC     = 1;
    localparam int DEF_ACTIVE_CYC    = 2;
    localparam int DEF_RECOVER_CYC   = 1;
    localparam int DEF_IORDY_TIMEOUT = 64;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous active-low bus strobe.
// Both stages reset to 1 so a strobe never looks asserted straight out of reset.
module sync2 (
    input  logic CLK7M,
    input  logic RESET_n,
    input  logic d,
    output logic q
);

    logic meta;

    // capture the pin, then re-time it once more before anyone uses it
    always_ff @(posedge CLK7M) begin
        // NOTE: non-blocking assignments so both stages sample the old value on the same edge.
        if (!RESET_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ide_pio_sequencer.sv
// ATA PIO cycle sequencer between Zorro II decode and the IDE interface.
// Times CS setup, IOR_n/IOW_n strobe, optional IORDY wait, recovery and the DTACK request,
// and answers boot ROM window accesses. All outputs are registered from the next state.
// Build option: define IDE_IORDY_EN to add the IORDY wait state and its timeout pulse.
module ide_pio_sequencer
    import ide_pkg::*;
#(
    parameter int SETUP_CYC     = DEF_SETUP_CYC,
    parameter int ACTIVE_CYC    = DEF_ACTIVE_CYC,
    parameter int RECOVER_CYC   = DEF_RECOVER_CYC,
    parameter int IORDY_TIMEOUT = DEF_IORDY_TIMEOUT
) (
    input  logic        CLK7M,
    input  logic        RESET_n,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        LDS_n,
    input  logic        RW,
    input  logic [16:12] ADDR,
    input  logic        ide_access,
    input  logic        ide_enable,
    input  logic        IORDY,
    output logic        IOR_n,
    output logic        IOW_n,
    output logic        IDECS1_n,
    output logic        IDECS2_n,
    output logic        IDE_ROMEN,
    output logic        AS_n_S4,
    output logic        DTACK,
    output logic        timeout
);

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LD  = CNT_W'(ACTIVE_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             cs2_sel, cs2_sel_d;
    logic             rd_sel, rd_sel_d;
    logic             uds_s, lds_s, ds_s, as_s, start;
    logic             cs_act, stb_act;
    logic             ior_d, iow_d, cs1_d, cs2_d, romen_d, dtack_d, timeout_d;

    sync2 u_sync_as  (.CLK7M(CLK7M), .RESET_n(RESET_n), .d(AS_n),  .q(AS_n_S4));
    sync2 u_sync_uds (.CLK7M(CLK7M), .RESET_n(RESET_n), .d(UDS_n), .q(uds_s));
    sync2 u_sync_lds (.CLK7M(CLK7M), .RESET_n(RESET_n), .d(LDS_n), .q(lds_s));

    assign as_s  = AS_n_S4;
    assign ds_s  = !(uds_s & lds_s);
    assign start = ide_access & ide_enable & !as_s & ds_s;

    // address bits between the window select and the CS select are decoded upstream
    logic unused_addr;
    assign unused_addr = ^ADDR[15:13];

`ifdef IDE_IORDY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(IORDY_TIMEOUT - 1);

    logic iordy_s;

    // single retiming flop on IORDY from the drive
    always_ff @(posedge CLK7M) begin
        if (!RESET_n) iordy_s <= 1'b0;
        else          iordy_s <= IORDY;
    end
`else
    // IORDY and its wait limit have no function without the IORDY gate
    logic unused_iordy;
    assign unused_iordy = IORDY | (IORDY_TIMEOUT == 0);
`endif

    // next state, counter, cycle attributes, and the output values for the next cycle
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state;
        cnt_d     = cnt;
        cs2_sel_d = cs2_sel;
        rd_sel_d  = rd_sel;
        timeout_d = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cs2_sel_d = ADDR[12];
                    rd_sel_d  = RW;
                    if (ADDR[16]) begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = ROMACK;
                    end
                end
            end
            SETUP: begin
                if (as_s) begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LD;
                end else if (cnt == '0) begin
                    state_d = ACTIVE;
                    cnt_d   = ACTIVE_LD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ACTIVE: begin
                if (as_s) begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LD;
                end else if (cnt == '0) begin
`ifdef IDE_IORDY_EN
                    if (iordy_s) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT_RDY;
                        cnt_d   = '0;
                    end
`else
                    state_d = ACK;
`endif
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
`ifdef IDE_IORDY_EN
            WAIT_RDY: begin
                if (as_s) begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LD;
                end else if (iordy_s) begin
                    state_d = ACK;
                end else if (cnt == TIMEOUT_LD) begin
                    state_d   = ACK;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
`endif
            ACK: begin
                if (as_s) begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LD;
                end
            end
            RECOVER: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - 1'b1;
            end
            ROMACK: begin
                if (as_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // CS spans setup through recovery; the strobe is held through ACK so read data stays valid
        cs_act  = state_d inside {SETUP, ACTIVE, WAIT_RDY, ACK, RECOVER};
        stb_act = state_d inside {ACTIVE, WAIT_RDY, ACK};
        cs1_d   = !(cs_act && !cs2_sel_d);
        cs2_d   = !(cs_act && cs2_sel_d);
        ior_d   = !(stb_act && rd_sel_d);
        iow_d   = !(stb_act && !rd_sel_d);
        romen_d = (state_d == ROMACK) && RW;
        dtack_d = (state_d == ACK) || (state_d == ROMACK && state == ROMACK);
    end

    // state, counter and registered outputs; reset drops every strobe at once
    always_ff @(posedge CLK7M) begin
        if (!RESET_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cs2_sel   <= 1'b0;
            rd_sel    <= 1'b0;
            IOR_n     <= 1'b1;
            IOW_n     <= 1'b1;
            IDECS1_n  <= 1'b1;
            IDECS2_n  <= 1'b1;
            IDE_ROMEN <= 1'b0;
            DTACK     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            cs2_sel   <= cs2_sel_d;
            rd_sel    <= rd_sel_d;
            IOR_n     <= ior_d;
            IOW_n     <= iow_d;
            IDECS1_n  <= cs1_d;
            IDECS2_n  <= cs2_d;
            IDE_ROMEN <= romen_d;
            DTACK     <= dtack_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Testbench for ide_pio_sequencer: table of bus cycles plus random cycles, every
// sample checked against a timeline model derived from the cycle timing rules.
// Honours IDE_IORDY_EN the same way the design does.
module tb_ide_pio_sequencer;

    localparam int T_SETUP   = 1;
    localparam int T_ACTIVE  = 2;
    localparam int T_RECOVER = 1;
    localparam int T_TIMEOUT = 64;

`ifdef IDE_IORDY_EN
    localparam int ACK_TMO  = 70;
    localparam int ACK_LATE = 12;
`else
    localparam int ACK_TMO  = 6;
    localparam int ACK_LATE = 6;
`endif

    logic       CLK7M = 1'b0;
    logic       RESET_n, AS_n, UDS_n, LDS_n, RW, ide_access, ide_enable, IORDY;
    logic [4:0] ADDR;
    logic       IOR_n, IOW_n, IDECS1_n, IDECS2_n, IDE_ROMEN, AS_n_S4, DTACK, timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // one bus cycle: inputs, AS_n release sample, IORDY rise sample, expected first DTACK sample (0 = none)
    typedef struct {
        logic       rw;
        logic [4:0] addr;
        logic       access;
        logic       enable;
        logic [1:0] ds_n;
        int         rel;
        int         iordy_t;
        int         exp_ack;
    } vec_t;

    vec_t vecs[$];

    ide_pio_sequencer dut (
        .CLK7M(CLK7M), .RESET_n(RESET_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .RW(RW), .ADDR(ADDR), .ide_access(ide_access), .ide_enable(ide_enable), .IORDY(IORDY),
        .IOR_n(IOR_n), .IOW_n(IOW_n), .IDECS1_n(IDECS1_n), .IDECS2_n(IDECS2_n),
        .IDE_ROMEN(IDE_ROMEN), .AS_n_S4(AS_n_S4), .DTACK(DTACK), .timeout(timeout)
    );

    always #70 CLK7M = ~CLK7M;

    function automatic logic [7:0] outs();
        return {IOR_n, IOW_n, IDECS1_n, IDECS2_n, IDE_ROMEN, DTACK, timeout, AS_n_S4};
    endfunction

    localparam logic [7:0] IDLE_OUTS = 8'b1111_0001;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected outputs at sample n (n posedges after AS_n falls), from the cycle timing rules:
    // 2 sync cycles, setup, active, optional IORDY wait, ack until AS_n release is seen, recovery.
    function automatic logic [7:0] model(input vec_t v, input int n);
        logic ior_n, iow_n, cs1_n, cs2_n, romen, dtack, tout, as4;
        bit   start, aborted, tmo, cs, stb;
        int   s, a, w, ack, fin;
        ior_n = 1'b1; iow_n = 1'b1; cs1_n = 1'b1; cs2_n = 1'b1;
        romen = 1'b0; dtack = 1'b0; tout = 1'b0;
        as4   = !(n >= 2 && n < v.rel + 2);
        start = v.access && v.enable && (v.ds_n != 2'b11);
        fin   = v.rel + 3;
        if (start && v.addr[4]) begin
            s   = 3;
            a   = s + T_SETUP;
            w   = a + T_ACTIVE;
            ack = w;
            tmo = 1'b0;
`ifdef IDE_IORDY_EN
            if (v.iordy_t + 2 > w + T_TIMEOUT) begin
                ack = w + T_TIMEOUT;
                tmo = 1'b1;
            end else if (v.iordy_t + 2 > w) begin
                ack = v.iordy_t + 2;
            end
`endif
            aborted = fin <= ack;
            cs      = n >= s && n < fin + T_RECOVER;
            stb     = n >= a && n < fin;
            cs1_n   = !(cs && !v.addr[0]);
            cs2_n   = !(cs && v.addr[0]);
            ior_n   = !(stb && v.rw);
            iow_n   = !(stb && !v.rw);
            dtack   = !aborted && n >= ack && n < fin;
            tout    = tmo && !aborted && n == ack;
        end else if (start) begin
            romen = v.rw && n >= 3 && n < fin;
            dtack = n >= 4 && n < fin;
        end
        return {ior_n, iow_n, cs1_n, cs2_n, romen, dtack, tout, as4};
    endfunction

    task automatic run_vec(input vec_t v, input int idx, input bit use_exp);
        int first;
        first = 0;
        @(negedge CLK7M);
        RW = v.rw; ADDR = v.addr; ide_access = v.access; ide_enable = v.enable;
        AS_n = 1'b0; UDS_n = v.ds_n[1]; LDS_n = v.ds_n[0];
        IORDY = (v.iordy_t == 0);
        for (int n = 1; n <= v.rel + 7; n++) begin
            @(negedge CLK7M);
            check($sformatf("vec%0d_n%0d", idx, n), 32'(outs()), 32'(model(v, n)));
            if (DTACK === 1'b1 && first == 0) first = n;
            if (n == v.rel) begin
                AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
            end
            if (n == v.iordy_t) IORDY = 1'b1;
        end
        if (use_exp) check($sformatf("vec%0d_ack_time", idx), first, v.exp_ack);
    endtask

    initial begin
        vec_t v;
        RESET_n = 1'b0; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
        ADDR = 5'h00; ide_access = 1'b0; ide_enable = 1'b1; IORDY = 1'b1;

        // reset state
        repeat (3) @(negedge CLK7M);
        check("reset_outs", 32'(outs()), 32'(IDLE_OUTS));
        RESET_n = 1'b1;
        repeat (2) @(negedge CLK7M);
        check("idle_after_reset", 32'(outs()), 32'(IDLE_OUTS));

        //                rw    addr   acc   en    ds_n   rel iordy ack
        vecs.push_back('{1'b1, 5'h10, 1'b1, 1'b1, 2'b00,  8,  0, 6});        // register read, CS1
        vecs.push_back('{1'b0, 5'h11, 1'b1, 1'b1, 2'b10,  8,  0, 6});        // register write, CS2
        vecs.push_back('{1'b1, 5'h00, 1'b1, 1'b1, 2'b01,  6,  0, 4});        // ROM read
        vecs.push_back('{1'b0, 5'h01, 1'b1, 1'b1, 2'b00,  5,  0, 4});        // ROM window write
        vecs.push_back('{1'b1, 5'h10, 1'b1, 1'b1, 2'b00,  3,  0, 0});        // abort seen in ACTIVE
        vecs.push_back('{1'b0, 5'h11, 1'b1, 1'b1, 2'b00,  1,  0, 0});        // abort seen in SETUP
        vecs.push_back('{1'b1, 5'h10, 1'b1, 1'b0, 2'b00,  8,  0, 0});        // IDE disabled
        vecs.push_back('{1'b1, 5'h10, 1'b0, 1'b1, 2'b00,  8,  0, 0});        // not our board
        vecs.push_back('{1'b1, 5'h10, 1'b1, 1'b1, 2'b11,  8,  0, 0});        // no data strobe
        vecs.push_back('{1'b1, 5'h10, 1'b1, 1'b1, 2'b00, 75, 200, ACK_TMO}); // IORDY never ready
        vecs.push_back('{1'b0, 5'h11, 1'b1, 1'b1, 2'b01, 15, 10, ACK_LATE}); // IORDY late
        vecs.push_back('{1'b1, 5'h11, 1'b1, 1'b1, 2'b10, 12,  0, 6});        // long hold in ACK
        foreach (vecs[i]) run_vec(vecs[i], i, 1'b1);

        // reset asserted while the strobe is low: everything drops on the next edge
        @(negedge CLK7M);
        RW = 1'b1; ADDR = 5'h10; ide_access = 1'b1; ide_enable = 1'b1; IORDY = 1'b1;
        AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
        repeat (4) @(negedge CLK7M);
        check("pre_reset_ior_low", 32'(IOR_n), 32'd0);
        RESET_n = 1'b0;
        for (int n = 5; n <= 6; n++) begin
            @(negedge CLK7M);
            check($sformatf("midreset_n%0d", n), 32'(outs()), 32'(IDLE_OUTS));
        end
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RESET_n = 1'b1;
        for (int n = 7; n <= 10; n++) begin
            @(negedge CLK7M);
            check($sformatf("postreset_n%0d", n), 32'(outs()), 32'(IDLE_OUTS));
        end

        // random cycles against the timeline model
        for (int i = 0; i < 40; i++) begin
            v.rw      = 1'($urandom_range(0, 1));
            v.addr    = 5'($urandom_range(0, 31));
            v.access  = ($urandom_range(0, 7) != 0);
            v.enable  = ($urandom_range(0, 7) != 0);
            v.ds_n    = 2'($urandom_range(0, 3));
            v.iordy_t = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 80)) : 0;
            v.rel     = (v.iordy_t > 0) ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 20));
            v.exp_ack = 0;
            run_vec(v, 100 + i, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
